aximm_over_stream_client: RTL and testbench
===========================================

Name: aximm_over_stream_client

Overview:
- AXI4-Lite slave that tunnels each local AXI read/write over a 256-bit AXI-Stream link to the remote AXI-MM-over-stream server.
- Sends one request packet per transaction and waits for the matching response packet.
- Returns the remote BRESP/RRESP and read data on the local AXI-Lite B/R channels.
- Sits on the local side of the Aurora link, one transaction outstanding at a time.

Parameters:
- ADDR_WIDTH, 64, AXI address width; fixed by packet format.
- DATA_WIDTH, 32, AXI data width; fixed by packet format.
- AXIS_WIDTH, 256, stream data width.
- TIMEOUT_CYCLES, 1000, response timeout in clk cycles; used only with RSP_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- S_AXI_AWADDR in 64; S_AXI_AWVALID in 1; S_AXI_AWPROT in 3 (ignored); S_AXI_AWREADY out 1
- S_AXI_WDATA in 32; S_AXI_WSTRB in 4 (ignored, full-word write); S_AXI_WVALID in 1; S_AXI_WREADY out 1
- S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1
- S_AXI_ARADDR in 64; S_AXI_ARVALID in 1; S_AXI_ARPROT in 3 (ignored); S_AXI_ARREADY out 1
- S_AXI_RDATA out 32; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1
- AXIS_TX_TDATA out 256; AXIS_TX_TVALID out 1; AXIS_TX_TLAST out 1; AXIS_TX_TREADY in 1 (requests)
- AXIS_RX_TDATA in 256; AXIS_RX_TVALID in 1; AXIS_RX_TLAST in 1 (ignored); AXIS_RX_TREADY out 1 (responses)

Behaviour:
- Reset (resetn=0 sampled at posedge): all READY/VALID outputs 0, TLAST 0, state INIT, holding flags cleared, priority flag = read-first. Reset mid-transaction abandons it silently; no B/R response is issued.
- Packet format: single beat, 32-bit words.
  - word0 = type: 1 READ_REQ, 2 WRITE_REQ, 3 READ_RSP, 4 WRITE_RSP.
  - words1-2 = address, low word first.
  - word3 = data.
  - word4 = resp, low 2 bits used.
  - Unused words are 0 on TX. TX_TLAST=1 whenever TX_TVALID=1.
- INIT: one cycle. Then AWREADY=WREADY=ARREADY=1 and RX_TREADY=1; go to IDLE.
- IDLE:
  - AW, W and AR are captured independently into holding registers. Each READY drops the cycle after its handshake and stays low while that channel holds data.
  - A write is complete when both AW and W are held, in either order.
  - Dispatch when a complete write or a held read exists. If both exist, the priority flag decides; the flag toggles to favour the other type after each dispatch.
  - Dispatch builds TX_TDATA, sets TX_TVALID=1 and goes to SEND.
- SEND: hold TDATA/TVALID stable until TREADY; on handshake TVALID<=0, go to WAIT_RSP.
- WAIT_RSP:
  - RX_TREADY=1. A beat whose type matches (3 for read, 4 for write) is accepted.
    - Read: RDATA<=word3, RRESP<=word4[1:0], RVALID<=1.
    - Write: BRESP<=word4[1:0], BVALID<=1.
    - Go to RESP.
  - Non-matching or unknown types are consumed and discarded; keep waiting.
- RESP: RX_TREADY=0. Hold VALID and data until the BREADY/RREADY handshake. Then clear VALID, clear the holding flags of the served channel, reassert that channel's READY(s) and RX_TREADY, and return to IDLE.
- Outside WAIT_RSP and RESP, RX_TREADY=1 after INIT, and all RX beats are discarded (drains stale responses).
- Minimum latency: AW+W or AR handshake → TX_TVALID 1 cycle; RX response handshake → B/RVALID 1 cycle.
- Address and data are not checked in the response; type alone matches.

Optional Feature:
- Macro: RSP_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_RSP and increments each cycle there.
  - If it reaches TIMEOUT_CYCLES with no matching response, issue the B or R response with resp=2'b10 (SLVERR) and RDATA=32'hDEAD_DEAD; go to RESP.
  - A late response later arriving in IDLE is discarded.
- Undefined: WAIT_RSP waits indefinitely; no counter logic is synthesised.

Decomposition:
- Shared package/include, also used by the server: message type codes (1..4), field word indices (TYPE=0, ADRL=1, ADRH=2, DATA=3, RESP=4), widths, SLVERR constant.
- One natural sub-module, aximm_stream_pkt_builder: combinational packing of type/addr/data into 256 bits, reusable by the server. The rest stays in one FSM.

Test Plan:
- Write 0x0000_0001_2345_6780 / 0xDEADBEEF → TX word0=2, word1=0x23456780, word2=0x00000001, word3=0xDEADBEEF, TLAST=1; RX {type=4, resp=0} → BVALID, BRESP=0.
- Read 0x1000 → TX word0=1, word1=0x1000; RX {3, data 0xCAFEF00D, resp 2} → RDATA=0xCAFEF00D, RRESP=2.
- W presented 5 cycles before AW → exactly one TX packet, issued 1 cycle after the AW handshake; WREADY low in between.
- AR and AW+W in the same cycle after reset → read packet first, then write; repeat simultaneous → write first. TX_TREADY held low 10 cycles → TDATA stable throughout.
- Waiting for a read, RX delivers type 4 then type 3 → first beat dropped, no BVALID; RVALID only after the type-3 beat.
- With RSP_TIMEOUT_EN and TIMEOUT_CYCLES=100, no RX for a read → RVALID after 100 cycles, RRESP=2'b10, RDATA=0xDEADDEAD; a later type-3 beat is dropped and the next write completes normally.

Source files
------------

// File: rtl/aximm_over_stream_client_pkg.sv
// AXI-MM-over-stream shared definitions: message codes, packet word
// layout, widths and FSM states. Used by both client and server.
package aximm_over_stream_client_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 32;
    localparam int AXIS_W = 256;
    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] MSG_READ_REQ  = 32'd1;
    localparam logic [WORD_W-1:0] MSG_WRITE_REQ = 32'd2;
    localparam logic [WORD_W-1:0] MSG_READ_RSP  = 32'd3;
    localparam logic [WORD_W-1:0] MSG_WRITE_RSP = 32'd4;

    localparam int W_TYPE = 0;
    localparam int W_ADRL = 1;
    localparam int W_ADRH = 2;
    localparam int W_DATA = 3;
    localparam int W_RESP = 4;

    localparam logic [1:0]        RESP_SLVERR = 2'b10;
    localparam logic [DATA_W-1:0] ERR_RDATA   = 32'hDEAD_DEAD;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SEND,
        ST_WAIT_RSP,
        ST_RESP
    } state_t;

    function automatic logic [WORD_W-1:0] pkt_word(
        input logic [AXIS_W-1:0] pkt,
        input int                idx
    );
        return pkt[idx*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/aximm_over_stream_client_if.sv
// Bus bundle of the client: local AXI4-Lite slave channels plus the
// request (TX) and response (RX) AXI-Stream links.
//   slave  : client view (AXI in, TX out, RX in)
//   master : peer view (AXI initiator, remote stream endpoint)
interface aximm_over_stream_client_if;
    import aximm_over_stream_client_pkg::*;

    logic [ADDR_W-1:0] S_AXI_AWADDR;
    logic              S_AXI_AWVALID;
    logic [2:0]        S_AXI_AWPROT;
    logic              S_AXI_AWREADY;
    logic [DATA_W-1:0] S_AXI_WDATA;
    logic [3:0]        S_AXI_WSTRB;
    logic              S_AXI_WVALID;
    logic              S_AXI_WREADY;
    logic [1:0]        S_AXI_BRESP;
    logic              S_AXI_BVALID;
    logic              S_AXI_BREADY;
    logic [ADDR_W-1:0] S_AXI_ARADDR;
    logic              S_AXI_ARVALID;
    logic [2:0]        S_AXI_ARPROT;
    logic              S_AXI_ARREADY;
    logic [DATA_W-1:0] S_AXI_RDATA;
    logic [1:0]        S_AXI_RRESP;
    logic              S_AXI_RVALID;
    logic              S_AXI_RREADY;

    logic [AXIS_W-1:0] AXIS_TX_TDATA;
    logic              AXIS_TX_TVALID;
    logic              AXIS_TX_TLAST;
    logic              AXIS_TX_TREADY;
    logic [AXIS_W-1:0] AXIS_RX_TDATA;
    logic              AXIS_RX_TVALID;
    logic              AXIS_RX_TLAST;
    logic              AXIS_RX_TREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_AWPROT,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_ARPROT,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY,
        output AXIS_TX_TDATA, AXIS_TX_TVALID, AXIS_TX_TLAST,
        input  AXIS_TX_TREADY,
        input  AXIS_RX_TDATA, AXIS_RX_TVALID, AXIS_RX_TLAST,
        output AXIS_RX_TREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_AWPROT,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_ARPROT,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY,
        input  AXIS_TX_TDATA, AXIS_TX_TVALID, AXIS_TX_TLAST,
        output AXIS_TX_TREADY,
        output AXIS_RX_TDATA, AXIS_RX_TVALID, AXIS_RX_TLAST,
        input  AXIS_RX_TREADY
    );

endinterface

// File: rtl/aximm_stream_pkt_builder.sv
// Combinational packer of one single-beat AXI-MM-over-stream packet.
// Ports: msg_type, addr, data, resp in; pkt out (unused words zero).
module aximm_stream_pkt_builder
    import aximm_over_stream_client_pkg::*;
#(
    parameter int AXIS_WIDTH = AXIS_W
) (
    input  logic [WORD_W-1:0]     msg_type,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     data,
    input  logic [1:0]            resp,
    output logic [AXIS_WIDTH-1:0] pkt
);

    always_comb begin
        pkt = '0;
        pkt[W_TYPE*WORD_W +: WORD_W] = msg_type;
        pkt[W_ADRL*WORD_W +: WORD_W] = addr[31:0];
        pkt[W_ADRH*WORD_W +: WORD_W] = addr[63:32];
        pkt[W_DATA*WORD_W +: WORD_W] = data;
        pkt[W_RESP*WORD_W +: WORD_W] = {30'd0, resp};
    end

endmodule

// File: rtl/aximm_over_stream_client.sv
// AXI4-Lite slave tunnelling each access over a 256-bit stream link,
// one transaction outstanding. Optional macro: RSP_TIMEOUT_EN.
// Ports: clk, resetn (sync, active low), bus (slave modport).
module aximm_over_stream_client
    import aximm_over_stream_client_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int AXIS_WIDTH     = 256,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                        clk,
    input  logic                        resetn,
    aximm_over_stream_client_if.slave   bus
);

    // Packet format fixes these widths.
    if (ADDR_WIDTH != ADDR_W || DATA_WIDTH != DATA_W ||
        AXIS_WIDTH != AXIS_W || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("aximm_over_stream_client: unsupported parameters");
    end

    state_t                 state;
    logic                   aw_rdy;
    logic                   w_rdy;
    logic                   ar_rdy;
    logic                   rx_rdy;
    logic                   aw_held;
    logic                   w_held;
    logic                   ar_held;
    logic [ADDR_WIDTH-1:0]  aw_addr;
    logic [ADDR_WIDTH-1:0]  ar_addr;
    logic [DATA_WIDTH-1:0]  w_data;
    logic                   prio_rd;
    logic                   cur_rd;
    logic [AXIS_WIDTH-1:0]  tx_data;
    logic                   tx_valid;
    logic                   tx_last;
    logic                   b_valid;
    logic [1:0]             b_resp;
    logic                   r_valid;
    logic [1:0]             r_resp;
    logic [DATA_WIDTH-1:0]  r_data;

`ifdef RSP_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0]        to_cnt;
`endif

    logic                   aw_hs;
    logic                   w_hs;
    logic                   ar_hs;
    logic                   rx_hs;
    logic                   wr_ok;
    logic                   rd_ok;
    logic                   pick_rd;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [DATA_WIDTH-1:0]  wr_data;
    logic [ADDR_WIDTH-1:0]  rd_addr;
    logic [WORD_W-1:0]      req_type;
    logic [AXIS_WIDTH-1:0]  req_pkt;
    logic [WORD_W-1:0]      rx_type;
    logic [DATA_WIDTH-1:0]  rx_data;
    logic [1:0]             rx_resp;
    logic                   rsp_match;

    assign aw_hs = bus.S_AXI_AWVALID & aw_rdy;
    assign w_hs  = bus.S_AXI_WVALID & w_rdy;
    assign ar_hs = bus.S_AXI_ARVALID & ar_rdy;
    assign rx_hs = bus.AXIS_RX_TVALID & rx_rdy;

    // A handshake this cycle counts as held, so the request leaves
    // on the same edge that captures the last needed channel.
    assign wr_ok   = (aw_held | aw_hs) & (w_held | w_hs);
    assign rd_ok   = ar_held | ar_hs;
    assign pick_rd = rd_ok & (~wr_ok | prio_rd);

    assign wr_addr = aw_held ? aw_addr : bus.S_AXI_AWADDR;
    assign wr_data = w_held ? w_data : bus.S_AXI_WDATA;
    assign rd_addr = ar_held ? ar_addr : bus.S_AXI_ARADDR;

    assign req_type = pick_rd ? MSG_READ_REQ : MSG_WRITE_REQ;

    aximm_stream_pkt_builder #(
        .AXIS_WIDTH (AXIS_WIDTH)
    ) u_builder (
        .msg_type (req_type),
        .addr     (pick_rd ? rd_addr : wr_addr),
        .data     (pick_rd ? '0 : wr_data),
        .resp     (2'b00),
        .pkt      (req_pkt)
    );

    assign rx_type   = pkt_word(bus.AXIS_RX_TDATA, W_TYPE);
    assign rx_data   = pkt_word(bus.AXIS_RX_TDATA, W_DATA);
    assign rx_resp   = bus.AXIS_RX_TDATA[W_RESP*WORD_W +: 2];
    assign rsp_match = rx_type == (cur_rd ? MSG_READ_RSP
                                          : MSG_WRITE_RSP);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= ST_INIT;
            aw_rdy   <= 1'b0;
            w_rdy    <= 1'b0;
            ar_rdy   <= 1'b0;
            rx_rdy   <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            ar_held  <= 1'b0;
            aw_addr  <= '0;
            ar_addr  <= '0;
            w_data   <= '0;
            prio_rd  <= 1'b1;
            cur_rd   <= 1'b0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            b_valid  <= 1'b0;
            b_resp   <= 2'b00;
            r_valid  <= 1'b0;
            r_resp   <= 2'b00;
            r_data   <= '0;
`ifdef RSP_TIMEOUT_EN
            to_cnt   <= '0;
`endif
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_addr <= bus.S_AXI_AWADDR;
                aw_rdy  <= 1'b0;
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= bus.S_AXI_WDATA;
                w_rdy  <= 1'b0;
            end
            if (ar_hs) begin
                ar_held <= 1'b1;
                ar_addr <= bus.S_AXI_ARADDR;
                ar_rdy  <= 1'b0;
            end

            unique case (state)
                ST_INIT: begin
                    aw_rdy <= 1'b1;
                    w_rdy  <= 1'b1;
                    ar_rdy <= 1'b1;
                    rx_rdy <= 1'b1;
                    state  <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (rd_ok | wr_ok) begin
                        tx_data  <= req_pkt;
                        tx_valid <= 1'b1;
                        tx_last  <= 1'b1;
                        cur_rd   <= pick_rd;
                        // Priority only flips when it actually arbitrated.
                        if (rd_ok & wr_ok)
                            prio_rd <= ~prio_rd;
                        state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (bus.AXIS_TX_TREADY) begin
                        tx_valid <= 1'b0;
                        tx_last  <= 1'b0;
`ifdef RSP_TIMEOUT_EN
                        to_cnt   <= '0;
`endif
                        state    <= ST_WAIT_RSP;
                    end
                end
                ST_WAIT_RSP: begin
                    if (rx_hs && rsp_match) begin
                        if (cur_rd) begin
                            r_valid <= 1'b1;
                            r_data  <= rx_data;
                            r_resp  <= rx_resp;
                        end else begin
                            b_valid <= 1'b1;
                            b_resp  <= rx_resp;
                        end
                        rx_rdy <= 1'b0;
                        state  <= ST_RESP;
                    end
`ifdef RSP_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        if (cur_rd) begin
                            r_valid <= 1'b1;
                            r_data  <= ERR_RDATA;
                            r_resp  <= RESP_SLVERR;
                        end else begin
                            b_valid <= 1'b1;
                            b_resp  <= RESP_SLVERR;
                        end
                        rx_rdy <= 1'b0;
                        state  <= ST_RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    if (cur_rd && r_valid && bus.S_AXI_RREADY) begin
                        r_valid <= 1'b0;
                        ar_held <= 1'b0;
                        ar_rdy  <= 1'b1;
                        rx_rdy  <= 1'b1;
                        state   <= ST_IDLE;
                    end else if (!cur_rd && b_valid &&
                                 bus.S_AXI_BREADY) begin
                        b_valid <= 1'b0;
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        aw_rdy  <= 1'b1;
                        w_rdy   <= 1'b1;
                        rx_rdy  <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    assign bus.S_AXI_AWREADY  = aw_rdy;
    assign bus.S_AXI_WREADY   = w_rdy;
    assign bus.S_AXI_ARREADY  = ar_rdy;
    assign bus.S_AXI_BVALID   = b_valid;
    assign bus.S_AXI_BRESP    = b_resp;
    assign bus.S_AXI_RVALID   = r_valid;
    assign bus.S_AXI_RRESP    = r_resp;
    assign bus.S_AXI_RDATA    = r_data;
    assign bus.AXIS_TX_TDATA  = tx_data;
    assign bus.AXIS_TX_TVALID = tx_valid;
    assign bus.AXIS_TX_TLAST  = tx_last;
    assign bus.AXIS_RX_TREADY = rx_rdy;

    // Protection bits, strobes, TLAST and unused packet words carry
    // no information for this client.
    logic unused_in;
    assign unused_in = &{1'b0,
                         bus.S_AXI_AWPROT,
                         bus.S_AXI_WSTRB,
                         bus.S_AXI_ARPROT,
                         bus.AXIS_RX_TLAST,
                         bus.AXIS_RX_TDATA[AXIS_W-1:W_RESP*WORD_W+2],
                         bus.AXIS_RX_TDATA[W_DATA*WORD_W-1:WORD_W]};

endmodule

// File: tb/tb_aximm_over_stream_client.sv
// Scoreboard bench for aximm_over_stream_client: directed requests,
// expected packets/responses queued and checked by negedge monitors.
module tb_aximm_over_stream_client;
    import aximm_over_stream_client_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    aximm_over_stream_client_if bus ();

    aximm_over_stream_client #(
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [255:0] exp_tx[$];
    logic [1:0]   exp_b[$];
    rd_t          exp_r[$];

    function automatic logic [255:0] mk(
        input logic [31:0] t, input logic [63:0] a,
        input logic [31:0] d, input logic [1:0] r);
        logic [255:0] p;
        p = '0;
        p[31:0]    = t;
        p[63:32]   = a[31:0];
        p[95:64]   = a[63:32];
        p[127:96]  = d;
        p[129:128] = r;
        return p;
    endfunction

    function automatic rd_t rd(input logic [31:0] d,
                               input logic [1:0] r);
        rd_t x;
        x.data = d;
        x.resp = r;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s", nm);
    endtask

    // Monitors: TX data checked every cycle it is valid (stability),
    // popped on handshake; B/R checked on handshake.
    always @(negedge clk) begin
        if (resetn) begin
            if (bus.AXIS_TX_TVALID) begin
                if (exp_tx.size() == 0) begin
                    fail("tx_unexpected");
                end else begin
                    chk("tx_data", bus.AXIS_TX_TDATA, exp_tx[0]);
                    chk("tx_last", bus.AXIS_TX_TLAST, 1);
                    if (bus.AXIS_TX_TREADY)
                        void'(exp_tx.pop_front());
                end
            end
            if (bus.S_AXI_BVALID && bus.S_AXI_BREADY) begin
                if (exp_b.size() == 0) begin
                    fail("b_unexpected");
                end else begin
                    chk("bresp", bus.S_AXI_BRESP, exp_b[0]);
                    void'(exp_b.pop_front());
                end
            end
            if (bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
                if (exp_r.size() == 0) begin
                    fail("r_unexpected");
                end else begin
                    chk("rdata", bus.S_AXI_RDATA, exp_r[0].data);
                    chk("rresp", bus.S_AXI_RRESP, exp_r[0].resp);
                    void'(exp_r.pop_front());
                end
            end
        end
    end

    task automatic issue(input bit a, input bit w, input bit r,
                         input logic [63:0] aa,
                         input logic [31:0] wd,
                         input logic [63:0] ra);
        bit ha, hw, hr;
        bus.S_AXI_AWADDR  = aa;
        bus.S_AXI_AWVALID = a;
        bus.S_AXI_WDATA   = wd;
        bus.S_AXI_WVALID  = w;
        bus.S_AXI_ARADDR  = ra;
        bus.S_AXI_ARVALID = r;
        for (int i = 0; i < 50; i++) begin
            if (!(bus.S_AXI_AWVALID || bus.S_AXI_WVALID ||
                  bus.S_AXI_ARVALID))
                break;
            @(negedge clk);
            ha = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
            hw = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
            hr = bus.S_AXI_ARVALID && bus.S_AXI_ARREADY;
            @(posedge clk);
            #1;
            if (ha) bus.S_AXI_AWVALID = 1'b0;
            if (hw) bus.S_AXI_WVALID  = 1'b0;
            if (hr) bus.S_AXI_ARVALID = 1'b0;
        end
        if (bus.S_AXI_AWVALID || bus.S_AXI_WVALID ||
            bus.S_AXI_ARVALID) begin
            fail("axi_request_timeout");
            bus.S_AXI_AWVALID = 1'b0;
            bus.S_AXI_WVALID  = 1'b0;
            bus.S_AXI_ARVALID = 1'b0;
        end
    endtask

    task automatic wait_tx(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (bus.AXIS_TX_TVALID && bus.AXIS_TX_TREADY) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        fail("tx_timeout");
    endtask

    task automatic rsp(input logic [255:0] p);
        bus.AXIS_RX_TDATA  = p;
        bus.AXIS_RX_TVALID = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.AXIS_RX_TREADY) begin
                @(posedge clk);
                #1;
                bus.AXIS_RX_TVALID = 1'b0;
                return;
            end
        end
        bus.AXIS_RX_TVALID = 1'b0;
        fail("rx_timeout");
    endtask

    task automatic wait_b();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.S_AXI_BVALID && bus.S_AXI_BREADY) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        fail("b_timeout");
    endtask

    task automatic wait_r();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        fail("r_timeout");
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.S_AXI_AWADDR   = '0;
        bus.S_AXI_AWVALID  = 1'b0;
        bus.S_AXI_AWPROT   = 3'd0;
        bus.S_AXI_WDATA    = '0;
        bus.S_AXI_WSTRB    = 4'hF;
        bus.S_AXI_WVALID   = 1'b0;
        bus.S_AXI_BREADY   = 1'b1;
        bus.S_AXI_ARADDR   = '0;
        bus.S_AXI_ARVALID  = 1'b0;
        bus.S_AXI_ARPROT   = 3'd0;
        bus.S_AXI_RREADY   = 1'b1;
        bus.AXIS_TX_TREADY = 1'b1;
        bus.AXIS_RX_TDATA  = '0;
        bus.AXIS_RX_TVALID = 1'b0;
        bus.AXIS_RX_TLAST  = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", bus.S_AXI_AWREADY, 0);
        chk("rst_wready", bus.S_AXI_WREADY, 0);
        chk("rst_arready", bus.S_AXI_ARREADY, 0);
        chk("rst_rx_tready", bus.AXIS_RX_TREADY, 0);
        chk("rst_tx_tvalid", bus.AXIS_TX_TVALID, 0);
        chk("rst_tx_tlast", bus.AXIS_TX_TLAST, 0);
        chk("rst_bvalid", bus.S_AXI_BVALID, 0);
        chk("rst_rvalid", bus.S_AXI_RVALID, 0);
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("init_awready", bus.S_AXI_AWREADY, 0);
        @(negedge clk);
        chk("idle_awready", bus.S_AXI_AWREADY, 1);
        chk("idle_wready", bus.S_AXI_WREADY, 1);
        chk("idle_arready", bus.S_AXI_ARREADY, 1);
        chk("idle_rx_tready", bus.AXIS_RX_TREADY, 1);
        @(posedge clk);
        #1;

        // Basic write
        exp_tx.push_back(mk(2, 64'h0000_0001_2345_6780,
                            32'hDEADBEEF, 0));
        issue(1, 1, 0, 64'h0000_0001_2345_6780, 32'hDEADBEEF, 0);
        wait_tx(n);
        chk("wr_latency", n, 1);
        exp_b.push_back(2'd0);
        rsp(mk(4, 0, 0, 0));
        wait_b();

        // Basic read
        exp_tx.push_back(mk(1, 64'h1000, 0, 0));
        issue(0, 0, 1, 0, 0, 64'h1000);
        wait_tx(n);
        exp_r.push_back(rd(32'hCAFEF00D, 2'd2));
        rsp(mk(3, 0, 32'hCAFEF00D, 2));
        wait_r();

        // W five cycles ahead of AW
        issue(0, 1, 0, 0, 32'h0BAD_F00D, 0);
        repeat (5) begin
            @(negedge clk);
            chk("wfirst_wready", bus.S_AXI_WREADY, 0);
            chk("wfirst_tvalid", bus.AXIS_TX_TVALID, 0);
        end
        @(posedge clk);
        #1;
        exp_tx.push_back(mk(2, 64'hFFFF_FFFF_FFFF_FFFC,
                            32'h0BAD_F00D, 0));
        issue(1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
        wait_tx(n);
        chk("aw_to_tx_latency", n, 1);
        exp_b.push_back(2'd1);
        rsp(mk(4, 0, 0, 1));
        wait_b();

        // Simultaneous, read wins; TX stalled 10 cycles
        bus.AXIS_TX_TREADY = 1'b0;
        exp_tx.push_back(mk(1, 64'h2000, 0, 0));
        exp_tx.push_back(mk(2, 64'h3000, 32'h1111_2222, 0));
        issue(1, 1, 1, 64'h3000, 32'h1111_2222, 64'h2000);
        repeat (10) @(posedge clk);
        #1 bus.AXIS_TX_TREADY = 1'b1;
        wait_tx(n);
        exp_r.push_back(rd(32'hAAAA_5555, 2'd0));
        rsp(mk(3, 0, 32'hAAAA_5555, 0));
        wait_r();
        wait_tx(n);
        exp_b.push_back(2'd0);
        rsp(mk(4, 0, 0, 0));
        wait_b();

        // Simultaneous again, write wins
        exp_tx.push_back(mk(2, 64'h4000, 32'h3333_4444, 0));
        exp_tx.push_back(mk(1, 64'h5000, 0, 0));
        issue(1, 1, 1, 64'h4000, 32'h3333_4444, 64'h5000);
        wait_tx(n);
        exp_b.push_back(2'd3);
        rsp(mk(4, 0, 0, 3));
        wait_b();
        wait_tx(n);
        exp_r.push_back(rd(32'h5566_7788, 2'd1));
        rsp(mk(3, 0, 32'h5566_7788, 1));
        wait_r();

        // Wrong-type beat while waiting for a read
        exp_tx.push_back(mk(1, 64'h6000, 0, 0));
        issue(0, 0, 1, 0, 0, 64'h6000);
        wait_tx(n);
        rsp(mk(4, 0, 32'h9999_9999, 0));
        @(negedge clk);
        chk("wrong_type_bvalid", bus.S_AXI_BVALID, 0);
        chk("wrong_type_rvalid", bus.S_AXI_RVALID, 0);
        @(posedge clk);
        #1;
        exp_r.push_back(rd(32'h1234_5678, 2'd0));
        rsp(mk(3, 0, 32'h1234_5678, 0));
        wait_r();

        // Stale beat in IDLE is drained, next read unaffected
        rsp(mk(3, 0, 32'hBADB_AD00, 0));
        @(negedge clk);
        chk("drain_rvalid", bus.S_AXI_RVALID, 0);
        @(posedge clk);
        #1;
        exp_tx.push_back(mk(1, 64'h7000, 0, 0));
        issue(0, 0, 1, 0, 0, 64'h7000);
        wait_tx(n);
        exp_r.push_back(rd(32'h0F0F_0F0F, 2'd0));
        rsp(mk(3, 0, 32'h0F0F_0F0F, 0));
        wait_r();

`ifdef RSP_TIMEOUT_EN
        exp_tx.push_back(mk(1, 64'h8000, 0, 0));
        issue(0, 0, 1, 0, 0, 64'h8000);
        wait_tx(n);
        exp_r.push_back(rd(32'hDEAD_DEAD, 2'b10));
        n = 0;
        while (!bus.S_AXI_RVALID && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("timeout_cycles", n, 100);
        wait_r();
        rsp(mk(3, 0, 32'h0000_0001, 0));
        @(negedge clk);
        chk("late_rsp_rvalid", bus.S_AXI_RVALID, 0);
        @(posedge clk);
        #1;
        exp_tx.push_back(mk(2, 64'h9000, 32'h7777_8888, 0));
        issue(1, 1, 0, 64'h9000, 32'h7777_8888, 0);
        wait_tx(n);
        exp_b.push_back(2'd0);
        rsp(mk(4, 0, 0, 0));
        wait_b();
`endif

        repeat (3) @(negedge clk);
        chk("tx_left", exp_tx.size(), 0);
        chk("b_left", exp_b.size(), 0);
        chk("r_left", exp_r.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
